// File: rtl/dekatron_step_sequencer.sv
// Command front-end for the dekatron counter: turns inc/dec/load/clear commands
// into single-step Request/Dec/Set transactions on the counter's Ready/Request handshake.
module dekatron_step_sequencer #(
    parameter int D_NUM   = 3,
    parameter int COUNT_W = 8
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               CmdValid,
    output logic               CmdReady,
    input  logic [1:0]         CmdOp,
    input  logic [COUNT_W-1:0] CmdCount,
    input  logic [D_NUM*4-1:0] CmdData,
    input  logic               Abort,
    input  logic               CntReady,
    output logic               CntRequest,
    output logic               CntDec,
    output logic               CntSet,
    output logic [D_NUM*4-1:0] CntIn,
    output logic               Busy,
    output logic               Done,
    output logic               Err,
    output logic [COUNT_W-1:0] StepsLeft,
    output logic [2:0]         DbgState
);

    // Handshakes: a command transfers on a rising edge with CmdValid & CmdReady;
    // each counter step is a one-cycle CntRequest issued only while CntReady is high.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 req_q, req_d;
    logic                 dec_q, dec_d;
    logic                 set_q, set_d;
    logic [D_NUM*4-1:0]   in_q, in_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [COUNT_W-1:0]   steps_q, steps_d;

    function automatic logic all_bcd(input logic [D_NUM*4-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < D_NUM; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        req_d       = 1'b0;
        dec_d       = dec_q;
        set_d       = set_q;
        in_d        = in_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        steps_d     = steps_q;

        case (state_q)
            S_IDLE: begin
                if (CmdValid && cmd_ready_q) begin
                    if (!CmdOp[1]) begin
                        dec_d       = CmdOp[0];
                        set_d       = 1'b0;
                        steps_d     = CmdCount;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                        // A zero-step command completes without touching the counter.
                        if (CmdCount == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else if (!CmdOp[0] && !all_bcd(CmdData)) begin
                        err_d = 1'b1;
                    end else begin
                        set_d       = 1'b1;
                        dec_d       = 1'b0;
                        in_d        = CmdOp[0] ? '0 : CmdData;
                        steps_d     = COUNT_W'(1);
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE, S_SETTLE: begin
                if (CntReady) begin
                    if ((steps_q != '0) && !Abort) begin
                        req_d   = 1'b1;
                        steps_d = steps_q - COUNT_W'(1);
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                state_d = S_SETTLE;
            end
            S_DONE: begin
                busy_d      = 1'b0;
                set_d       = 1'b0;
                dec_d       = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            req_q       <= 1'b0;
            dec_q       <= 1'b0;
            set_q       <= 1'b0;
            in_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            steps_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            req_q       <= req_d;
            dec_q       <= dec_d;
            set_q       <= set_d;
            in_q        <= in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            steps_q     <= steps_d;
        end
    end

    assign CmdReady   = cmd_ready_q;
    assign CntRequest = req_q;
    assign CntDec     = dec_q;
    assign CntSet     = set_q;
    assign CntIn      = in_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Err        = err_q;
    assign StepsLeft  = steps_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Bench for dekatron_step_sequencer: directed scenarios plus random commands,
// every output compared each cycle against a step-scheduling model and a BCD counter model.
module tb_dekatron_step_sequencer;

    localparam int D_NUM   = 3;
    localparam int COUNT_W = 8;
    localparam int DW      = D_NUM * 4;
    localparam int CNT_MOD = 10 ** D_NUM;

    logic               Clk = 1'b0;
    logic               Rst_n = 1'b1;
    logic               CmdValid = 1'b0;
    logic [1:0]         CmdOp = 2'b00;
    logic [COUNT_W-1:0] CmdCount = '0;
    logic [DW-1:0]      CmdData = '0;
    logic               Abort = 1'b0;
    logic               CntReady = 1'b1;
    logic               CmdReady;
    logic               CntRequest;
    logic               CntDec;
    logic               CntSet;
    logic [DW-1:0]      CntIn;
    logic               Busy;
    logic               Done;
    logic               Err;
    logic [COUNT_W-1:0] StepsLeft;
    logic [2:0]         dbg_state;

    dekatron_step_sequencer #(.D_NUM(D_NUM), .COUNT_W(COUNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdCount(CmdCount), .CmdData(CmdData), .Abort(Abort),
        .CntReady(CntReady), .CntRequest(CntRequest), .CntDec(CntDec),
        .CntSet(CntSet), .CntIn(CntIn), .Busy(Busy), .Done(Done), .Err(Err),
        .StepsLeft(StepsLeft), .DbgState(dbg_state)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait budget expired at %0t", name, $time);
    endtask

    function automatic logic is_bcd(input logic [DW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < D_NUM; i++) if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic int bcd_to_int(input logic [DW-1:0] v);
        int r;
        r = 0;
        for (int i = D_NUM - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    // Model: a command is a list of steps; a step decision happens one edge after accept,
    // then two edges after each issued step, and only while the counter is ready.
    logic          m_busy = 1'b0, m_finish = 1'b0;
    logic          m_req = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic          m_dec = 1'b0, m_set = 1'b0;
    logic [DW-1:0] m_in = '0;
    int            m_steps = 0, m_age = 0, m_gap = 1;
    int            pulses = 0, dones = 0, cnt_val = 0;

    always @(posedge Clk) begin
        m_req = 1'b0;
        m_done = 1'b0;
        m_err = 1'b0;
        if (!Rst_n) begin
            m_busy = 1'b0; m_finish = 1'b0; m_dec = 1'b0; m_set = 1'b0;
            m_in = '0; m_steps = 0; m_age = 0; m_gap = 1;
        end else if (m_finish) begin
            m_finish = 1'b0; m_busy = 1'b0; m_set = 1'b0; m_dec = 1'b0;
        end else if (!m_busy) begin
            if (CmdValid) begin
                if (CmdOp < 2'd2) begin
                    m_dec = CmdOp[0]; m_set = 1'b0; m_steps = int'(CmdCount);
                    m_busy = 1'b1; m_age = 0; m_gap = 1;
                    if (m_steps == 0) begin m_done = 1'b1; m_finish = 1'b1; end
                end else if (CmdOp == 2'd2 && !is_bcd(CmdData)) begin
                    m_err = 1'b1;
                end else begin
                    m_set = 1'b1; m_dec = 1'b0; m_in = (CmdOp == 2'd3) ? '0 : CmdData;
                    m_steps = 1; m_busy = 1'b1; m_age = 0; m_gap = 1;
                end
            end
        end else begin
            m_age++;
            if (m_age >= m_gap && CntReady) begin
                if (m_steps > 0 && !Abort) begin
                    m_req = 1'b1; m_steps--; m_age = 0; m_gap = 2;
                end else begin
                    m_done = 1'b1; m_finish = 1'b1;
                end
            end
        end
        #1;
        check("cmd_ready", CmdReady, !m_busy);
        check("cnt_request", CntRequest, m_req);
        check("cnt_dec", CntDec, m_dec);
        check("cnt_set", CntSet, m_set);
        check("cnt_in", CntIn, m_in);
        check("busy", Busy, m_busy);
        check("done", Done, m_done);
        check("err", Err, m_err);
        check("steps_left", StepsLeft, m_steps);
        if (Rst_n && Done === 1'b1) dones++;
        if (Rst_n && CntRequest === 1'b1) begin
            pulses++;
            if (CntSet) cnt_val = bcd_to_int(CntIn);
            else if (CntDec) cnt_val = (cnt_val + CNT_MOD - 1) % CNT_MOD;
            else cnt_val = (cnt_val + 1) % CNT_MOD;
        end
    end

    task automatic send_cmd(input logic [1:0] op, input int cnt, input logic [DW-1:0] data);
        int guard;
        guard = 0;
        @(negedge Clk);
        while (CmdReady !== 1'b1 && guard < 300) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 300) timeout_fail("cmd_ready_wait");
        CmdValid = 1'b1;
        CmdOp = op;
        CmdCount = cnt[COUNT_W-1:0];
        CmdData = data;
        @(negedge Clk);
        CmdValid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (!(CmdReady === 1'b1 && Busy === 1'b0) && guard < 300) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 300) timeout_fail(name);
    endtask

    task automatic wait_pulses(input string name, input int base, input int n);
        int guard;
        guard = 0;
        while (pulses - base < n && guard < 300) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 300) timeout_fail(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int p0, p1, d0;
    logic [1:0]    r_op;
    logic [DW-1:0] r_data;

    initial begin
        #1 Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_cmd_ready", CmdReady, 1);
        check("rst_request", CntRequest, 0);
        check("rst_busy", Busy, 0);
        check("rst_steps", StepsLeft, 0);
        check("rst_state", dbg_state, 0);
        Rst_n = 1'b1;

        p0 = pulses; d0 = dones;
        send_cmd(2'b00, 5, '0);
        wait_idle("inc5_idle");
        check("inc5_pulses", pulses - p0, 5);
        check("inc5_dones", dones - d0, 1);
        check("inc5_counter", cnt_val, 5);
        check("inc5_steps", StepsLeft, 0);

        p0 = pulses;
        send_cmd(2'b01, 3, '0);
        wait_idle("dec3_idle");
        check("dec3_pulses", pulses - p0, 3);
        check("dec3_counter", cnt_val, 2);

        p0 = pulses;
        send_cmd(2'b00, 0, '0);
        check("inc0_done_e1", Done, 1);
        wait_idle("inc0_idle");
        check("inc0_pulses", pulses - p0, 0);

        p0 = pulses;
        send_cmd(2'b10, 0, 12'h255);
        wait_idle("load_idle");
        check("load_pulses", pulses - p0, 1);
        check("load_counter", cnt_val, 255);
        check("load_cnt_in_hold", CntIn, 12'h255);

        p0 = pulses;
        send_cmd(2'b10, 0, 12'h2A5);
        check("badload_err", Err, 1);
        check("badload_busy", Busy, 0);
        check("badload_ready", CmdReady, 1);
        repeat (3) @(negedge Clk);
        check("badload_pulses", pulses - p0, 0);
        check("badload_counter", cnt_val, 255);

        p0 = pulses;
        send_cmd(2'b00, 10, '0);
        wait_pulses("stall_p4", p0, 4);
        CntReady = 1'b0;
        p1 = pulses;
        repeat (7) @(negedge Clk);
        check("stall_no_pulse", pulses - p1, 0);
        CntReady = 1'b1;
        wait_idle("stall_idle");
        check("stall_pulses", pulses - p0, 10);
        check("stall_counter", cnt_val, 265);

        p0 = pulses;
        send_cmd(2'b00, 10, '0);
        wait_pulses("abort_p3", p0, 3);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        wait_pulses("abort_p4", p0, 4);
        @(negedge Clk);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        wait_idle("abort_idle");
        check("abort_pulses", pulses - p0, 4);
        check("abort_steps", StepsLeft, 6);
        check("abort_counter", cnt_val, 269);

        p0 = pulses;
        send_cmd(2'b00, 8, '0);
        wait_pulses("rst_mid_p2", p0, 2);
        check("rst_mid_req_before", CntRequest, 1);
        Rst_n = 1'b0;
        #1;
        check("rst_mid_request", CntRequest, 0);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_ready", CmdReady, 1);
        check("rst_mid_steps", StepsLeft, 0);
        check("rst_mid_cnt_in", CntIn, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        p1 = pulses;
        repeat (6) @(negedge Clk);
        check("rst_mid_no_resume", pulses - p1, 0);
        check("rst_mid_ready_after", CmdReady, 1);

        repeat (40) begin
            r_op = 2'($urandom_range(0, 3));
            r_data = '0;
            for (int i = 0; i < D_NUM; i++) r_data[i*4 +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) r_data[4*$urandom_range(0, D_NUM - 1) +: 4] = 4'($urandom_range(10, 15));
            send_cmd(r_op, $urandom_range(0, 12), r_data);
            for (int g = 0; g < 300; g++) begin
                if (CmdReady === 1'b1 && Busy === 1'b0) break;
                @(negedge Clk);
                CntReady = ($urandom_range(0, 9) < 7);
                Abort = ($urandom_range(0, 19) == 0);
                CmdValid = ($urandom_range(0, 3) == 0);
                CmdOp = 2'($urandom_range(0, 3));
                CmdCount = COUNT_W'($urandom_range(0, 12));
                if (CmdReady === 1'b1) CmdValid = 1'b0;
            end
            CmdValid = 1'b0;
            CntReady = 1'b1;
            Abort = 1'b0;
        end

        repeat (3) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
